// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the CDC FIFO write- and read-side controllers.
// Pointer codecs work on 32-bit zero-extended values, so they suit any pointer width up to 32.
package cdc_fifo_pkg;

  localparam int CDC_FIFO_ADDR_WIDTH = 4;
  localparam int CDC_FIFO_MAX_PTR_W  = 32;

  function automatic logic [CDC_FIFO_MAX_PTR_W-1:0] bin2gray(
    input logic [CDC_FIFO_MAX_PTR_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a narrower pointer leave the prefix XOR unchanged.
  function automatic logic [CDC_FIFO_MAX_PTR_W-1:0] gray2bin(
    input logic [CDC_FIFO_MAX_PTR_W-1:0] g
  );
    logic [CDC_FIFO_MAX_PTR_W-1:0] b;
    b[CDC_FIFO_MAX_PTR_W-1] = g[CDC_FIFO_MAX_PTR_W-1];
    for (int i = CDC_FIFO_MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/cdc_fifo_wr_ctrl.sv
// Write-domain controller of the async CDC FIFO: RAM write port, binary/Gray write pointers,
// and full / almost_full / level / sticky overflow derived from the synchronized read pointer.
module cdc_fifo_wr_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = CDC_FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  // Write handshake: a word is taken on any edge where wr_en is high and full is low;
  // there is no ready path, so a write while full is dropped and recorded in overflow.
  logic             accept;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rq_full_pattern;

  logic [PTR_W-1:0] wr_bin_d, wr_bin_q;
  logic [PTR_W-1:0] wr_ptr_gray_d, wr_ptr_gray_q;
  logic [PTR_W-1:0] level_d, level_q;
  logic             full_d, full_q;
  logic             almost_full_d, almost_full_q;
  logic             overflow_d, overflow_q;

  gray_to_binary #(.W(PTR_W)) u_rd_g2b (
    .gray (rd_ptr_gray_sync),
    .bin  (rd_bin)
  );

  always_comb begin
    accept          = wr_en & ~full_q & ~reset;
    rq_full_pattern = {~rd_ptr_gray_sync[PTR_W-1:PTR_W-2], rd_ptr_gray_sync[PTR_W-3:0]};
    wr_bin_d        = wr_bin_q + {{(PTR_W-1){1'b0}}, accept};
    wr_ptr_gray_d   = PTR_W'(bin2gray(CDC_FIFO_MAX_PTR_W'(wr_bin_d)));
    // Full when the write pointer is exactly one lap ahead of the (stale) read pointer.
    full_d          = (wr_ptr_gray_d == rq_full_pattern);
    level_d         = wr_bin_d - rd_bin;
    almost_full_d   = (32'(level_d) >= ALMOST_FULL);
    overflow_d      = overflow_q | (wr_en & full_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_bin_q      <= '0;
      wr_ptr_gray_q <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign mem_we      = accept;
  assign mem_waddr   = wr_bin_q[ADDR_WIDTH-1:0];
  assign mem_wdata   = wr_data;
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Directed bench for cdc_fifo_wr_ctrl: reset, fill, overflow, drain, pointer wrap, mid-run reset.
module tb_cdc_fifo_wr_ctrl;

  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]   rd_ptr_gray_sync;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   level;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  cdc_fifo_wr_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .ALMOST_FULL(12)) dut (
    .clock            (clock),
    .reset            (reset),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .mem_we           (mem_we),
    .mem_waddr        (mem_waddr),
    .mem_wdata        (mem_wdata),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .level            (level),
    .overflow         (overflow)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int lvl, input logic f, input logic af,
                           input logic ov);
    chk({tag, "_level"}, 32'(level), 32'(lvl));
    chk({tag, "_full"}, 32'(full), 32'(f));
    chk({tag, "_af"}, 32'(almost_full), 32'(af));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h3C;
    rd_ptr_gray_sync = 5'b00000;

    // Reset held with a write requested
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_gray", 32'(wr_ptr_gray), 32'd0);
    chk_flags("rst", 0, 1'b0, 1'b0, 1'b0);

    reset = 1'b0;
    wr_en = 1'b0;
    step();
    chk("rel_gray", 32'(wr_ptr_gray), 32'h00);
    chk("rel_level", 32'(level), 32'd0);

    // Fill 16 words with rq = 0
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      #1;
      chk("fill_we", 32'(mem_we), 32'd1);
      chk("fill_addr", 32'(mem_waddr), 32'(i));
      chk("fill_data", 32'(mem_wdata), 32'(i));
      step();
      chk_flags("fill", i + 1, (i == 15), (i + 1 >= 12), 1'b0);
    end
    wr_en = 1'b0;
    chk("fill_gray", 32'(wr_ptr_gray), 32'b11000);

    // Overflow attempt while full
    wr_en = 1'b1;
    wr_data = 8'hAA;
    #1;
    chk("ovf_we", 32'(mem_we), 32'd0);
    step();
    wr_en = 1'b0;
    chk_flags("ovf", 16, 1'b1, 1'b1, 1'b1);
    chk("ovf_gray", 32'(wr_ptr_gray), 32'b11000);

    // Drain: read pointer reaches 4, then 5
    rd_ptr_gray_sync = 5'b00110;
    step();
    chk_flags("drain4", 12, 1'b0, 1'b1, 1'b1);
    rd_ptr_gray_sync = 5'b00111;
    step();
    chk_flags("drain5", 11, 1'b0, 1'b0, 1'b1);

    // Accepted write after overflow: overflow stays set
    wr_en = 1'b1;
    wr_data = 8'h55;
    #1;
    chk("post_ovf_we", 32'(mem_we), 32'd1);
    chk("post_ovf_addr", 32'(mem_waddr), 32'd0);
    step();
    wr_en = 1'b0;
    chk_flags("post_ovf", 12, 1'b0, 1'b1, 1'b1);
    chk("post_ovf_gray", 32'(wr_ptr_gray), 32'b11001);

    // Empty it: read pointer = 17
    rd_ptr_gray_sync = 5'b11001;
    step();
    chk_flags("empty", 0, 1'b0, 1'b0, 1'b1);

    // 14 writes take wr_bin from 17 to 31
    for (int k = 0; k < 14; k++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h80 + k);
      #1;
      chk("wrap_addr", 32'(mem_waddr), 32'((17 + k) % 16));
      step();
      chk_flags("wrap", k + 1, 1'b0, (k + 1 >= 12), 1'b1);
    end
    wr_en = 1'b0;
    chk("gray31", 32'(wr_ptr_gray), 32'b10000);

    // Write across the wrap together with rq -> 20
    wr_en = 1'b1;
    wr_data = 8'hC3;
    rd_ptr_gray_sync = 5'b11110;
    #1;
    chk("wrap_edge_addr", 32'(mem_waddr), 32'd15);
    chk("wrap_edge_data", 32'(mem_wdata), 32'hC3);
    step();
    wr_en = 1'b0;
    chk("gray0", 32'(wr_ptr_gray), 32'b00000);
    chk_flags("simul", 12, 1'b0, 1'b1, 1'b1);

    // Read pointer 25 -> level 7
    rd_ptr_gray_sync = 5'b10101;
    step();
    chk_flags("lvl7", 7, 1'b0, 1'b0, 1'b1);

    // Mid-cycle asynchronous reset
    #2;
    reset = 1'b1;
    wr_en = 1'b1;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_gray", 32'(wr_ptr_gray), 32'd0);
    chk_flags("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    rd_ptr_gray_sync = 5'b00000;
    step();
    reset = 1'b0;
    wr_data = 8'h77;
    #1;
    chk("after_rst_we", 32'(mem_we), 32'd1);
    chk("after_rst_addr", 32'(mem_waddr), 32'd0);
    step();
    wr_en = 1'b0;
    chk("after_rst_gray", 32'(wr_ptr_gray), 32'b00001);
    chk_flags("after_rst", 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
